shift_arbiter_amisha: RTL

- Sequencer/arbiter that shares one combinational 8-bit barrel shifter stage between two requesters.
- Accepts {data, amount} requests over valid/ready and arbitrates round-robin.
- Drives the shared shifter's data and amount inputs from held registers, then returns the registered result, tagged with the requester id, over a valid/ready response channel.
- Sits between the switch/button front-end and the existing barrel shifter stage instance.

---
 rtl/shift_arbiter_amisha.sv | 115 +++++++++++
 1 files changed

// File: rtl/shift_arbiter_amisha.sv
// Round-robin sequencer sharing one combinational barrel shifter stage between
// two requesters. Each transaction is accept -> shift -> response.
module shift_arbiter_amisha #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk_amisha,
   input  logic          rst_n_amisha,
   input  logic          req0_valid_amisha,
   output logic          req0_ready_amisha,
   input  logic [DW-1:0] req0_data_amisha,
   input  logic [AW-1:0] req0_amt_amisha,
   input  logic          req1_valid_amisha,
   output logic          req1_ready_amisha,
   input  logic [DW-1:0] req1_data_amisha,
   input  logic [AW-1:0] req1_amt_amisha,
   output logic [DW-1:0] sh_a_amisha,
   output logic [AW-1:0] sh_amt_amisha,
   input  logic [DW-1:0] sh_y_amisha,
   output logic          rsp_valid_amisha,
   input  logic          rsp_ready_amisha,
   output logic [DW-1:0] rsp_data_amisha,
   output logic          rsp_id_amisha,
   output logic          busy_amisha,
   output logic [7:0]    txn_cnt_amisha
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]    state_q;
   logic          rr_q;
   logic          id_q;
   logic [DW-1:0] sh_a_q;
   logic [AW-1:0] sh_amt_q;
   logic          rsp_valid_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_id_q;
   logic [7:0]    txn_cnt_q;

   logic          grant_any;
   logic          grant_id;
   logic          accept;
   logic          rsp_fire;

   // On a tie the requester that did not complete last wins (rr holds last winner).
   always_comb begin
      grant_any = req0_valid_amisha | req1_valid_amisha;
      grant_id  = 1'b0;
      if (req0_valid_amisha && req1_valid_amisha) begin
         grant_id = ~rr_q;
      end else if (req1_valid_amisha) begin
         grant_id = 1'b1;
      end
   end

   // Ready is also gated by reset so nothing appears accepted while reset is held.
   assign accept            = rst_n_amisha && (state_q == ST_IDLE) && grant_any;
   assign req0_ready_amisha = accept && !grant_id;
   assign req1_ready_amisha = accept && grant_id;
   assign rsp_fire          = (state_q == ST_RESP) && rsp_ready_amisha;

   always_ff @(posedge clk_amisha) begin
      if (!rst_n_amisha) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b1;
         id_q        <= 1'b0;
         sh_a_q      <= '0;
         sh_amt_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         txn_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_any) begin
                  sh_a_q   <= grant_id ? req1_data_amisha : req0_data_amisha;
                  sh_amt_q <= grant_id ? req1_amt_amisha  : req0_amt_amisha;
                  id_q     <= grant_id;
                  state_q  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               rsp_data_q  <= sh_y_amisha;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_fire) begin
                  rr_q        <= rsp_id_q;
                  txn_cnt_q   <= txn_cnt_q + 8'd1;
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign sh_a_amisha      = sh_a_q;
   assign sh_amt_amisha    = sh_amt_q;
   assign rsp_valid_amisha = rsp_valid_q;
   assign rsp_data_amisha  = rsp_data_q;
   assign rsp_id_amisha    = rsp_id_q;
   assign busy_amisha      = (state_q != ST_IDLE);
   assign txn_cnt_amisha   = txn_cnt_q;

endmodule
